// File: rtl/pe_pkg.sv
// Shared types and default widths for the Horner/GEMM processing element.
package pe_pkg;

    // Operating mode selected by gemm_uno
    typedef enum logic [1:0] {
        GEMM = 2'b00,
        DIV  = 2'b01,
        EXP  = 2'b10,
        LOG  = 2'b11
    } pe_mode_e;

    // Unary-evaluation sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        DONE = 2'b10
    } pe_state_e;

    localparam int INT_BW_D = 5;
    localparam int FRA_BW_D = 5;
    localparam int MUL_BW_D = 16;
    localparam int ACC_BW_D = 32;
    localparam int TERMS_D  = 4;

endpackage

// File: rtl/pe_sat_trunc.sv
// Narrows a wide fixed-point value (2*FRA_BW fraction bits) back to the
// INT_BW.FRA_BW operand format, clamping to the narrow range on overflow.
module pe_sat_trunc #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 5,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32
) (
    input  logic signed [ACC_BW-1:0] v_i,
    output logic signed [MUL_BW-1:0] q_o,
    output logic                     clamp_o
);

    localparam int HI = INT_BW + 2*FRA_BW;
    localparam int NB = INT_BW + FRA_BW + 1;
    localparam logic signed [ACC_BW-1:0] MAXV = ACC_BW'((64'sd1 <<< HI) - 64'sd1);
    // Two's complement: ~(2^HI - 1) == -2^HI
    localparam logic signed [ACC_BW-1:0] MINV = ~MAXV;

    logic [NB-1:0] n;

    // Range check, then either clamp or drop the extra fraction bits
    always_comb begin
        clamp_o = 1'b0;
        n       = v_i[HI:FRA_BW];
        if (v_i > MAXV) begin
            n       = {1'b0, {(NB-1){1'b1}}};
            clamp_o = 1'b1;
        end else if (v_i < MINV) begin
            n       = {1'b1, {(NB-1){1'b0}}};
            clamp_o = 1'b1;
        end
    end

    assign q_o = {{(MUL_BW-NB){n[NB-1]}}, n};

endmodule

// File: rtl/pe_horner.sv
// Processing element: GEMM multiply-accumulate in IDLE, or a TERMS-step
// Horner polynomial evaluation (div/exp/log approximations) from a
// shift-loaded coefficient bank.
module pe_horner
    import pe_pkg::*;
#(
    parameter int INT_BW = INT_BW_D,
    parameter int FRA_BW = FRA_BW_D,
    parameter int MUL_BW = MUL_BW_D,
    parameter int ACC_BW = ACC_BW_D,
    parameter int TERMS  = TERMS_D
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               gemm_uno,
    input  logic                     start,
    input  logic signed [ACC_BW-1:0] mac_i,
    input  logic signed [MUL_BW-1:0] var_i,
    input  logic signed [MUL_BW-1:0] x_i,
    input  logic signed [MUL_BW-1:0] wc_i,
    input  logic                     wc_vld_i,
    input  logic signed [ACC_BW-1:0] o_i,
    output logic signed [ACC_BW-1:0] mac_o,
    output logic signed [ACC_BW-1:0] o_o,
    output logic signed [MUL_BW-1:0] var_o,
    output logic signed [MUL_BW-1:0] x_o,
    output logic signed [MUL_BW-1:0] wc_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     sat_o
);

    localparam int KW = $clog2(TERMS);
    localparam int XW = ACC_BW - MUL_BW;

    pe_state_e                state_q;
    pe_mode_e                 mode_q;
    logic signed [MUL_BW-1:0] wreg_q, ireg_q, vreg_q;
    logic signed [MUL_BW-1:0] vhold_q, acc_q;
    logic signed [MUL_BW-1:0] coef_q [TERMS];
    logic signed [ACC_BW-1:0] oreg_q;
    logic [KW-1:0]            k_q;
    logic                     sticky_q, busy_q, done_q, sat_q;

    logic signed [MUL_BW-1:0] coef_sel, seed_sat, iter_sat;
    logic                     seed_clamp, iter_clamp;
    logic signed [ACC_BW-1:0] w_ext, i_ext, acc_ext, vh_ext, coef_ext;
    logic signed [ACC_BW-1:0] gemm_sum, p;

    // Operands widened to accumulator width so products wrap at ACC_BW
    assign w_ext    = {{XW{wreg_q[MUL_BW-1]}}, wreg_q};
    assign i_ext    = {{XW{ireg_q[MUL_BW-1]}}, ireg_q};
    assign acc_ext  = {{XW{acc_q[MUL_BW-1]}}, acc_q};
    assign vh_ext   = {{XW{vhold_q[MUL_BW-1]}}, vhold_q};
    assign coef_sel = coef_q[k_q];
    // Coefficient aligned to the 2*FRA_BW product fraction point
    assign coef_ext = {{(XW-FRA_BW){coef_sel[MUL_BW-1]}}, coef_sel, {FRA_BW{1'b0}}};

    assign gemm_sum = w_ext * i_ext + o_i;
    assign p        = acc_ext * vh_ext + coef_ext;

    pe_sat_trunc #(
        .INT_BW(INT_BW), .FRA_BW(FRA_BW), .MUL_BW(MUL_BW), .ACC_BW(ACC_BW)
    ) u_sat_seed (
        .v_i    (mac_i),
        .q_o    (seed_sat),
        .clamp_o(seed_clamp)
    );

    pe_sat_trunc #(
        .INT_BW(INT_BW), .FRA_BW(FRA_BW), .MUL_BW(MUL_BW), .ACC_BW(ACC_BW)
    ) u_sat_iter (
        .v_i    (p),
        .q_o    (iter_sat),
        .clamp_o(iter_clamp)
    );

    // Pass-through registers, coefficient bank, sequencer and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= GEMM;
            wreg_q   <= '0;
            ireg_q   <= '0;
            vreg_q   <= '0;
            vhold_q  <= '0;
            acc_q    <= '0;
            oreg_q   <= '0;
            k_q      <= '0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
            for (int j = 0; j < TERMS; j++) coef_q[j] <= '0;
        end else begin
            wreg_q <= wc_i;
            ireg_q <= x_i;
            vreg_q <= var_i;
            done_q <= 1'b0;

            // Bank is frozen while it is being walked
            if (wc_vld_i && state_q != ITER) begin
                for (int j = TERMS-1; j > 0; j--) coef_q[j] <= coef_q[j-1];
                coef_q[0] <= wc_i;
            end

            case (state_q)
                IDLE: begin
                    if (start && gemm_uno != GEMM) begin
                        mode_q   <= pe_mode_e'(gemm_uno);
                        acc_q    <= seed_sat;
                        vhold_q  <= var_i;
                        k_q      <= KW'(TERMS-1);
                        sticky_q <= seed_clamp;
                        busy_q   <= 1'b1;
                        state_q  <= ITER;
                    end else if (gemm_uno == GEMM) begin
                        oreg_q <= gemm_sum;
                    end
                end
                ITER: begin
                    acc_q    <= iter_sat;
                    sticky_q <= sticky_q | iter_clamp;
                    k_q      <= k_q - KW'(1);
                    if (k_q == '0) begin
                        // Full-width last step is the result; mode_q is a
                        // unary mode whenever ITER was entered
                        if (mode_q != GEMM) oreg_q <= p;
                        sat_q   <= sticky_q | iter_clamp;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    sat_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mac_o  = oreg_q;
    assign o_o    = oreg_q;
    assign wc_o   = wreg_q;
    assign x_o    = ireg_q;
    assign var_o  = vreg_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sat_o  = sat_q;

endmodule

// File: tb/tb_pe_horner.sv
// Bench for pe_horner: table-driven GEMM vectors, Horner runs checked
// through a result queue, plus reset/saturation/ignore sequences.
module tb_pe_horner;
    import pe_pkg::*;

    localparam int TERMS = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         gemm_uno;
    logic               start;
    logic signed [31:0] mac_i, o_i;
    logic signed [15:0] var_i, x_i, wc_i;
    logic               wc_vld_i;
    logic signed [31:0] mac_o, o_o;
    logic signed [15:0] var_o, x_o, wc_o;
    logic               busy_o, done_o, sat_o;

    always #5 clk = ~clk;

    pe_horner dut (
        .clk(clk), .rst(rst), .gemm_uno(gemm_uno), .start(start),
        .mac_i(mac_i), .var_i(var_i), .x_i(x_i), .wc_i(wc_i),
        .wc_vld_i(wc_vld_i), .o_i(o_i), .mac_o(mac_o), .o_o(o_o),
        .var_o(var_o), .x_o(x_o), .wc_o(wc_o), .busy_o(busy_o),
        .done_o(done_o), .sat_o(sat_o)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic signed [31:0] o;
        bit                 s;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic signed [15:0] wc, x, vr;
        logic signed [31:0] o, exp_o;
    } gv_t;
    gv_t gv[7];

    longint cm[TERMS];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mac_o"}, mac_o, 0);
        chk({tag, "_o_o"}, o_o, 0);
        chk({tag, "_var_o"}, var_o, 0);
        chk({tag, "_x_o"}, x_o, 0);
        chk({tag, "_wc_o"}, wc_o, 0);
        chk({tag, "_busy_o"}, busy_o, 0);
        chk({tag, "_done_o"}, done_o, 0);
        chk({tag, "_sat_o"}, sat_o, 0);
    endtask

    function automatic longint satm(input longint v, inout bit st);
        if (v > 32767) begin st = 1; return 1023; end
        if (v < -32768) begin st = 1; return -1024; end
        return v >>> 5;
    endfunction

    function automatic void model(input longint mac, input longint vr,
                                  output longint res, output bit st);
        longint acc, p;
        st = 0;
        res = 0;
        acc = satm(mac, st);
        for (int k = TERMS-1; k >= 0; k--) begin
            p = acc * vr + (cm[k] <<< 5);
            p = longint'(int'(p));
            res = p;
            acc = satm(p, st);
        end
    endfunction

    task automatic load_coef(input logic signed [15:0] v);
        wc_i = v;
        wc_vld_i = 1'b1;
        @(posedge clk); #1;
        wc_vld_i = 1'b0;
        for (int j = TERMS-1; j > 0; j--) cm[j] = cm[j-1];
        cm[0] = v;
    endtask

    // Start one evaluation, wait (bounded) for done, compare against queue head.
    // Returns in the DONE cycle.
    task automatic run_h(input logic [1:0] md, input logic signed [31:0] mac,
                         input logic signed [15:0] vr, input bit disturb,
                         input logic signed [31:0] eo, input bit es);
        int cnt;
        bit got;
        exp_t e;
        sb.push_back('{eo, es});
        wc_vld_i = 1'b0;
        gemm_uno = md;
        mac_i = mac;
        var_i = vr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        got = 0;
        while (!got && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) begin
                chk("iter_busy", busy_o, 1);
                chk("iter_done_low", done_o, 0);
            end
            if (done_o) got = 1;
            if (disturb && cnt == 1) begin
                start = 1'b1;
                wc_vld_i = 1'b1;
                wc_i = 16'sd99;
                gemm_uno = GEMM;
                var_i = -vr;
                mac_i = 32'sh12345;
            end
            if (disturb && cnt == 2) begin
                start = 1'b0;
                wc_vld_i = 1'b0;
                wc_i = 16'sd2;
                x_i = 16'sd3;
                o_i = 32'sd1;
            end
        end
        chk("done_seen", got, 1);
        chk("latency", cnt, TERMS);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("horner_o_o", o_o, e.o);
            chk("horner_mac_o", mac_o, e.o);
            chk("horner_sat_o", sat_o, e.s);
            chk("done_busy", busy_o, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] c, vr;
        logic signed [31:0] mac;
        longint eo;
        bit es;
        int dn;
        exp_t e;

        gv[0] = '{16'sd3, 16'sd4, 16'sd11, 32'sd10, 32'sd22};
        gv[1] = '{-16'sd5, 16'sd7, -16'sd3, 32'sd100, 32'sd65};
        gv[2] = '{16'sh8000, 16'sh8000, 16'sd1, 32'sd0, 32'sd1073741824};
        gv[3] = '{16'sh8000, 16'sh8000, 16'sd2, 32'sh40000000, 32'sh80000000};
        gv[4] = '{16'sd32767, -16'sd1, 16'sd3, -32'sd1, -32'sd32768};
        gv[5] = '{16'sd0, 16'sd1234, 16'sd4, -32'sd7, -32'sd7};
        gv[6] = '{16'sd200, 16'sd300, 16'sd5, 32'sh7FFFFFF0, -32'sd2147423664};
        for (int j = 0; j < TERMS; j++) cm[j] = 0;

        rst = 1'b1; gemm_uno = GEMM; start = 1'b0; mac_i = 0; var_i = 16'sd9;
        x_i = 16'sd8; wc_i = 16'sd7; wc_vld_i = 1'b0; o_i = 32'sd6;
        @(posedge clk); @(posedge clk); #1;
        chk_zero("reset");
        rst = 1'b0;

        // GEMM vectors, each held two cycles
        for (int i = 0; i < 7; i++) begin
            gemm_uno = GEMM;
            wc_i = gv[i].wc; x_i = gv[i].x; var_i = gv[i].vr; o_i = gv[i].o;
            sb.push_back('{gv[i].exp_o, 1'b0});
            @(posedge clk); #1;
            chk("gemm_wc_o", wc_o, gv[i].wc);
            chk("gemm_x_o", x_o, gv[i].x);
            chk("gemm_var_o", var_o, gv[i].vr);
            @(posedge clk); #1;
            e = sb.pop_front();
            chk("gemm_o_o", o_o, e.o);
            chk("gemm_mac_o", mac_o, e.o);
        end

        // Polynomial of all-ones coefficients at x=1.0 -> 4.0
        for (int j = 0; j < TERMS; j++) load_coef(16'sd32);
        run_h(DIV, 32'sd0, 16'sd32, 1'b0, 32'sd4096, 1'b0);
        @(posedge clk); #1;
        chk("post_done_low", done_o, 0);
        chk("post_busy_low", busy_o, 0);

        // Same run with start/coef/mode/var disturbances during ITER
        run_h(EXP, 32'sd0, 16'sd32, 1'b1, 32'sd4096, 1'b0);
        @(posedge clk); #1;
        chk("done_hold_o_o", o_o, 4096);
        chk("single_done", done_o, 0);
        @(posedge clk); #1;
        chk("gemm_resume_o_o", o_o, 7);
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done_o || busy_o) dn++;
        end
        chk("no_second_done", dn, 0);

        // Model-checked evaluations with random coefficients and operands
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < TERMS; j++) begin
                c = 16'($urandom_range(4000)) - 16'sd2000;
                load_coef(c);
            end
            vr = (r == 0) ? 16'($urandom_range(64)) : 16'($urandom);
            mac = (r == 0) ? 32'($urandom_range(60000)) - 32'sd30000 : 32'($urandom);
            model(longint'(mac), longint'(vr), eo, es);
            run_h((r == 1) ? LOG : EXP, mac, vr, 1'b0, 32'(eo), es);
            @(posedge clk); #1;
            chk("rand_done_low", done_o, 0);
        end

        // Reset during the second iteration
        for (int j = 0; j < TERMS; j++) load_coef(16'sd32);
        gemm_uno = DIV; mac_i = 0; var_i = 16'sd32; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("mid_iter_reset");
        for (int j = 0; j < TERMS; j++) cm[j] = 0;
        gemm_uno = GEMM; wc_i = 0; x_i = 0; o_i = 32'sd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_eval_o_o", o_o, 5);
        run_h(DIV, 32'sd0, 16'sd32, 1'b0, 32'sd0, 1'b0);
        @(posedge clk); #1;

        // Seed saturation, both directions, zero coefficients
        run_h(DIV, 32'sh7FFFFFFF, 16'sd32, 1'b0, 32'sd32736, 1'b1);
        @(posedge clk); #1;
        chk("sat_cleared", sat_o, 0);
        run_h(LOG, 32'sh80000000, 16'sd32, 1'b0, -32'sd32768, 1'b1);
        @(posedge clk); #1;
        chk("final_busy_low", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_horner.md
PE_HORNER -- requirements
Module: pe_horner

Interface
REQ-001 Parameters SHALL be INT_BW=5 (integer bits), FRA_BW=5 (fraction bits), MUL_BW=16 (multiplier operand width), ACC_BW=32 (accumulator width, at least 2*MUL_BW), TERMS=4 (coefficient bank depth, 2..16).
REQ-002 Ports SHALL be, in this order:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- gemm_uno  in  2  mode: 00 gemm, 01 div, 10 exp, 11 log.
- start  in  1  starts a unary evaluation.
- mac_i  in  ACC_BW  signed unary seed.
- var_i  in  MUL_BW  signed unary variable.
- x_i  in  MUL_BW  signed activation.
- wc_i  in  MUL_BW  signed weight or coefficient.
- wc_vld_i  in  1  shift wc_i into the coefficient bank.
- o_i  in  ACC_BW  signed partial sum.
- mac_o, o_o  out  ACC_BW  result register.
- var_o, x_o, wc_o  out  MUL_BW  registered pass-through of var_i, x_i, wc_i.
- busy_o, done_o, sat_o  out  1  status.
REQ-003 There SHALL be one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, ITER and DONE.
REQ-005 wreg, ireg and vreg SHALL register wc_i, x_i and var_i every cycle in every state; wc_o, x_o and var_o SHALL equal them.
REQ-006 In IDLE with gemm_uno=00, oreg SHALL load wreg*ireg+o_i each cycle (full precision, wrapping at ACC_BW); mac_o and o_o SHALL equal oreg.
REQ-007 When wc_vld_i=1 outside ITER, the bank SHALL shift: coef[0]<=wc_i and coef[k]<=coef[k-1]; in ITER, wc_vld_i SHALL be ignored.
REQ-008 Narrowing SAT(v) SHALL work as follows:
- if v > 2^(INT_BW+2*FRA_BW)-1, use the maximum narrow value {0, all ones (INT_BW+FRA_BW)};
- if v < -2^(INT_BW+2*FRA_BW), use the minimum narrow value {1, all zeros};
- otherwise use v[INT_BW+2*FRA_BW : FRA_BW];
- the result is sign-extended to MUL_BW, and a clamp sets an internal sticky flag.
REQ-009 In IDLE, start=1 with gemm_uno!=00 SHALL:
- latch the mode;
- set acc=SAT(mac_i) and vreg-hold=var_i;
- set k=TERMS-1 and clear the sticky flag;
- enter ITER.
REQ-010 start with gemm_uno=00 SHALL be ignored.
REQ-011 Each ITER cycle SHALL compute p=acc*vhold+(sign-extended coef[k] << FRA_BW) at ACC_BW, then set acc<=SAT(p) and k<=k-1.
REQ-012 In the ITER cycle with k=0, p SHALL go to oreg and the FSM SHALL enter DONE.
REQ-013 oreg SHALL hold during ITER.
REQ-014 DONE SHALL last one cycle: done_o=1, sat_o=sticky flag, then IDLE.
REQ-015 Latency: start sampled at edge N gives done_o high in cycle N+TERMS+1.
REQ-016 busy_o SHALL be 1 in ITER and DONE.
REQ-017 start, mode changes and var_i changes while busy SHALL be ignored.
REQ-018 In DONE with gemm_uno=00, oreg SHALL take the Horner result, not the gemm sum; gemm resumes the next cycle.

Reset
REQ-019 rst=1 at a clock edge SHALL, in any state including mid-ITER, clear the following:
- all registers and oreg;
- every coefficient;
- acc, k and the sticky flag;
- the FSM, to IDLE.
REQ-020 All outputs SHALL read 0 in the cycle after reset.

Structure
REQ-021 Package pe_pkg SHALL hold:
- mode enum (GEMM=00, DIV=01, EXP=10, LOG=11);
- FSM state enum;
- default width localparams.
REQ-022 Sub-module pe_sat_trunc SHALL implement SAT (combinational, parametrised by INT_BW, FRA_BW, MUL_BW, ACC_BW), instanced twice (seed and iteration).

Verification
REQ-023 Gemm: wc_i=3, x_i=4, o_i=10 held -> o_o=22 two cycles after apply; wc_o=3, x_o=4 one cycle after.
REQ-024 Horner with defaults:
- stimulus: load four coefficients 32 (1.0); gemm_uno=01, mac_i=0, var_i=32, start for one cycle;
- response: busy_o high, done_o in cycle N+5, o_o=4096 (4.0), sat_o=0.
REQ-025 Saturation: mac_i=0x7FFFFFFF, var_i=32, coefficients 0 -> o_o=32736, sat_o=1 with done_o.
REQ-026 Ignored events during ITER:
- second start -> only one done_o pulse;
- wc_vld_i with wc_i=99 -> result unchanged;
- gemm_uno flipping to 00 -> result unchanged.
REQ-027 Reset mid-ITER: rst during the second iteration -> next cycle busy_o=0, o_o=0; then a fresh evaluation with no coefficients reloaded, mac_i=0 -> o_o=0.
REQ-028 Negative clamp: mac_i=0x80000000, var_i=32, coefficients 0 -> o_o=-32768, sat_o=1.
